// File: rtl/grf_scoreboard.sv
// General-purpose register file with a per-register pending (scoreboard) bit.
//
// Reads are combinational, with an optional same-cycle forward of the writeback data.
// The pending bit for a register is set when an instruction that writes it is issued.
// It is cleared when that register is written back, or when the pipeline is flushed.
// Each accepted write produces a one-cycle registered trace record.
//
// Parameters:
//   DATA_W   - register data width
//   ADDR_W   - address width; the file has 2**ADDR_W registers
//   NUM_RD   - number of combinational read ports (1..4)
//   BYPASS   - 1: forward an accepted same-cycle write to matching read ports
//   ZERO_REG - 1: r0 reads 0, ignores writes and issue, and is never pending
//
// Ports:
//   clk_i, rst_ni       - clock (rising edge) and asynchronous active-low reset
//   pc_i                - PC of the writing instruction; used only for the trace
//   we_i/waddr_i/wdata_i- writeback enable, address and data
//   raddr_i             - read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata_o             - read data, port i at [i*DATA_W +: DATA_W]
//   rvalid_o            - per port: 1 = operand ready (not pending)
//   issue_en_i/addr_i   - mark a destination register pending
//   flush_i             - clear all pending bits
//   pend_cnt_o          - registered count of pending registers
//   trace_*_o           - registered record of the last accepted write
module grf_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              pc_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rvalid_o,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_addr_i,
  input  logic                     flush_i,
  output logic [ADDR_W:0]          pend_cnt_o,
  output logic                     trace_valid_o,
  output logic [31:0]              trace_pc_o,
  output logic [ADDR_W-1:0]        trace_addr_o,
  output logic [DATA_W-1:0]        trace_data_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              trace_valid_q;
  logic [31:0]       trace_pc_q;
  logic [ADDR_W-1:0] trace_addr_q;
  logic [DATA_W-1:0] trace_data_q;

  logic wr_acc, iss_acc;

  assign wr_acc  = we_i && !(ZERO_REG && (waddr_i == '0));
  assign iss_acc = issue_en_i && !(ZERO_REG && (issue_addr_i == '0));

  // Ordering matters: flush first, then writeback clears, then issue sets.
  // When issue and writeback target the same register, the newer producer
  // (the issue) wins and the register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end
    if (wr_acc) begin
      pend_d[waddr_i] = 1'b0;
    end
    if (iss_acc) begin
      pend_d[issue_addr_i] = 1'b1;
    end
  end

  // pend_cnt_o is registered, so count the next-state bits here.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_acc) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // The trace fields keep their last value; only the valid flag drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= wr_acc;
      if (wr_acc) begin
        trace_pc_q   <= pc_i;
        trace_addr_q <= waddr_i;
        trace_data_q <= wdata_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] port_data;
    logic              port_vld;

    assign ra = raddr_i[g*ADDR_W +: ADDR_W];

    always_comb begin
      port_data = regs_q[ra];
      port_vld  = !pend_q[ra];
      if (ZERO_REG && (ra == '0)) begin
        port_data = '0;
        port_vld  = 1'b1;
      end else if (BYPASS && wr_acc && (waddr_i == ra)) begin
        port_data = wdata_i;
        port_vld  = 1'b1;
      end
    end

    assign rdata_o[g*DATA_W +: DATA_W] = port_data;
    assign rvalid_o[g]                 = port_vld;
  end

  assign pend_cnt_o    = cnt_q;
  assign trace_valid_o = trace_valid_q;
  assign trace_pc_o    = trace_pc_q;
  assign trace_addr_o  = trace_addr_q;
  assign trace_data_o  = trace_data_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;

  typedef struct packed {
    logic [31:0]   pc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } tr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      pc;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NR*AW-1:0] raddr;
  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             flush;

  // Two instances share the stimulus: a = bypass + zero reg, b = neither.
  logic [NR*DW-1:0] rdata_a, rdata_b;
  logic [NR-1:0]    rvalid_a, rvalid_b;
  logic [AW:0]      cnt_a, cnt_b;
  logic             tv_a, tv_b;
  logic [31:0]      tpc_a, tpc_b;
  logic [AW-1:0]    tad_a, tad_b;
  logic [DW-1:0]    tda_a, tda_b;

  grf_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_a), .rvalid_o(rvalid_a), .issue_en_i(issue_en),
    .issue_addr_i(issue_addr), .flush_i(flush), .pend_cnt_o(cnt_a), .trace_valid_o(tv_a),
    .trace_pc_o(tpc_a), .trace_addr_o(tad_a), .trace_data_o(tda_a)
  );

  grf_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b0), .ZERO_REG(1'b0)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_b), .rvalid_o(rvalid_b), .issue_en_i(issue_en),
    .issue_addr_i(issue_addr), .flush_i(flush), .pend_cnt_o(cnt_b), .trace_valid_o(tv_b),
    .trace_pc_o(tpc_b), .trace_addr_o(tad_b), .trace_data_o(tda_b)
  );

  // Reference model, index 0 = instance a, 1 = instance b.
  logic [DW-1:0] m_reg  [2][32];
  logic          m_pend [2][32];
  logic          m_tv   [2];
  tr_t           q_a[$];
  tr_t           q_b[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[d][r]  = '0;
        m_pend[d][r] = 1'b0;
      end
      m_tv[d] = 1'b0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  // Applies the current inputs as of a rising edge.
  task automatic model_update(input int d);
    logic z, wacc, iacc;
    tr_t  t;
    z    = (d == 0);
    wacc = we && !(z && waddr == '0);
    iacc = issue_en && !(z && issue_addr == '0);
    if (flush) for (int r = 0; r < 32; r++) m_pend[d][r] = 1'b0;
    if (wacc) begin
      m_reg[d][waddr]  = wdata;
      m_pend[d][waddr] = 1'b0;
      t = '{pc: pc, addr: waddr, data: wdata};
      if (d == 0) q_a.push_back(t);
      else q_b.push_back(t);
    end
    if (iacc) m_pend[d][issue_addr] = 1'b1;
    m_tv[d] = wacc;
  endtask

  task automatic check_dut(input int d);
    logic          z, b, wacc, ev, gv, gtv;
    logic [AW-1:0] ra;
    logic [DW-1:0] ed, gd;
    logic [AW:0]   ecnt, gcnt;
    tr_t           e;
    z    = (d == 0);
    b    = (d == 0);
    wacc = we && !(z && waddr == '0);
    for (int p = 0; p < NR; p++) begin
      ra = raddr[p*AW +: AW];
      if (z && ra == '0) begin
        ed = '0;
        ev = 1'b1;
      end else if (b && wacc && waddr == ra) begin
        ed = wdata;
        ev = 1'b1;
      end else begin
        ed = m_reg[d][ra];
        ev = !m_pend[d][ra];
      end
      gd = (d == 0) ? rdata_a[p*DW +: DW] : rdata_b[p*DW +: DW];
      gv = (d == 0) ? rvalid_a[p] : rvalid_b[p];
      check($sformatf("dut%0d rdata%0d r%0d", d, p, ra), {32'h0, gd}, {32'h0, ed});
      check($sformatf("dut%0d rvalid%0d r%0d", d, p, ra), {63'h0, gv}, {63'h0, ev});
    end
    ecnt = '0;
    for (int r = 0; r < 32; r++) ecnt = ecnt + {5'h0, m_pend[d][r]};
    gcnt = (d == 0) ? cnt_a : cnt_b;
    check($sformatf("dut%0d pend_cnt", d), {58'h0, gcnt}, {58'h0, ecnt});
    gtv = (d == 0) ? tv_a : tv_b;
    check($sformatf("dut%0d trace_valid", d), {63'h0, gtv}, {63'h0, m_tv[d]});
    if (gtv) begin
      if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
        check($sformatf("dut%0d unexpected trace", d), 64'h1, 64'h0);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        check($sformatf("dut%0d trace_pc", d), {32'h0, (d == 0) ? tpc_a : tpc_b},
              {32'h0, e.pc});
        check($sformatf("dut%0d trace_addr", d), {59'h0, (d == 0) ? tad_a : tad_b},
              {59'h0, e.addr});
        check($sformatf("dut%0d trace_data", d), {32'h0, (d == 0) ? tda_a : tda_b},
              {32'h0, e.data});
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst rdata_a", {32'h0, rdata_a[63:32] | rdata_a[31:0]}, 64'h0);
    check("rst rdata_b", {32'h0, rdata_b[63:32] | rdata_b[31:0]}, 64'h0);
    check("rst cnt", {52'h0, cnt_a, cnt_b}, 64'h0);
    check("rst trace_valid", {62'h0, tv_a, tv_b}, 64'h0);
    check("rst trace fields", {22'h0, tad_a, tad_b, tpc_a | tda_a | tpc_b | tda_b}, 64'h0);
  endtask

  // Inputs are driven 1 time unit after a rising edge, checked at the falling edge.
  task automatic step();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic set_idle();
    pc = '0; we = 1'b0; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
    raddr = {a3, a2, a1, a0};
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] p);
    we = 1'b1; waddr = a; wdata = d; pc = p;
  endtask

  task automatic drive_iss(input logic [AW-1:0] a);
    issue_en = 1'b1; issue_addr = a;
  endtask

  initial begin
    set_idle();
    set_rd(5'd0, 5'd1, 5'd5, 5'd31);
    model_reset();
    #3;
    check_reset_outputs();
    check_dut(0);
    check_dut(1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;

    // Scoreboard: issue r3, then write it back.
    set_idle(); set_rd(5'd3, 5'd3, 5'd0, 5'd1); drive_iss(5'd3); step();
    set_idle(); step();
    drive_wr(5'd3, 32'h1234_5678, 32'h1000); step();
    set_idle(); step();

    // Bypass: r3 pending again, writeback and read in the same cycle.
    drive_iss(5'd3); step();
    set_idle(); drive_wr(5'd3, 32'hA5A5_A5A5, 32'h1010); step();
    set_idle(); step();

    // Zero register: write and issue r0 together.
    set_rd(5'd0, 5'd0, 5'd3, 5'd0);
    drive_wr(5'd0, 32'hFFFF_FFFF, 32'h2000); drive_iss(5'd0); step();
    set_idle(); step();
    step();

    // Collisions: issue and write r9 together, then flush with issue r4.
    set_rd(5'd9, 5'd4, 5'd9, 5'd0);
    drive_wr(5'd9, 32'h1, 32'h2100); drive_iss(5'd9); step();
    set_idle(); drive_iss(5'd12); step();
    set_idle(); step();
    flush = 1'b1; drive_iss(5'd4); step();
    set_idle(); step();

    // Back-to-back trace pulses and four ports.
    drive_wr(5'd1, 32'h11, 32'h3000); step();
    drive_wr(5'd2, 32'h22, 32'h3004); step();
    set_idle(); set_rd(5'd1, 5'd2, 5'd1, 5'd0); step();
    step();
    drive_wr(5'd2, 32'h33, 32'h3008); step();
    drive_wr(5'd2, 32'h44, 32'h300C); step();
    set_idle(); step();
    step();

    // Asynchronous reset one cycle after a write, between edges.
    set_rd(5'd5, 5'd7, 5'd5, 5'd7);
    drive_wr(5'd5, 32'hDEAD_BEEF, 32'h4000); drive_iss(5'd7); step();
    set_idle();
    #1;
    check_dut(0);
    check_dut(1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    check_dut(0);
    check_dut(1);
    #4 rst_n = 1'b1;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    step();

    // Random traffic on a small address range to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      we         = 1'($urandom_range(0, 1));
      waddr      = 5'($urandom_range(0, 7));
      wdata      = $urandom;
      pc         = $urandom;
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = 5'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      step();
    end
    set_idle();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
